// File: rtl/shot_exchange_if.sv
// Byte-level UART link between the shot protocol controller and the UART core.
// The controller side is the master: it issues transmit requests and consumes received bytes.
interface shot_exchange_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;

    modport master (
        output tx_data,
        output tx_start,
        input  rx_data,
        input  rx_valid,
        input  tx_busy
    );

    modport slave (
        input  tx_data,
        input  tx_start,
        output rx_data,
        output rx_valid,
        output tx_busy
    );
endinterface

// File: rtl/shot_exchange.sv
// Turn and shot protocol controller between the UART byte link and game_board.
// Exchanges two-byte SHOT/RESULT frames and holds board-facing signals across one frame_tick.
module shot_exchange #(
    parameter int          TIMEOUT_CYCLES = 100_000_000,
    parameter logic [7:0]  HDR_SHOT       = 8'hA5,
    parameter logic [7:0]  HDR_RES        = 8'h5A
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  is_host,
    input  logic                  fire,
    input  logic [7:0]            mouse_pos,
    input  logic                  ships_ready,
    input  logic                  frame_tick,
    input  logic [1:0]            msg_out,
    shot_exchange_if.master       uart,
    output logic [7:0]            check_in,
    output logic                  addres_recieved,
    output logic [1:0]            msg_in,
    output logic                  my_turn,
    output logic                  timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE,
        TX_SH_H,
        TX_SH_A,
        WAIT_RES_H,
        WAIT_RES_D,
        APPLY_RES,
        RX_SH_A,
        EVAL,
        CAPTURE,
        TX_RES_H,
        TX_RES_D
    } state_t;

    // Each transmitted byte: request, one settling cycle, then wait for the UART to drain.
    typedef enum logic [1:0] {
        PH_SEND,
        PH_GAP,
        PH_DRAIN
    } phase_t;

    state_t           state, state_nxt;
    phase_t           phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [7:0]       shot_addr, shot_addr_nxt;
    logic [1:0]       res_code, res_code_nxt;
    logic [7:0]       tx_data_r, tx_data_nxt;
    logic             tx_start_r, tx_start_nxt;
    logic [7:0]       check_in_nxt;
    logic             addr_rcv_nxt;
    logic [1:0]       msg_in_nxt;
    logic             my_turn_nxt;
    logic             timeout_nxt;
    logic [7:0]       tx_byte;
    state_t           tx_after;

    assign uart.tx_data  = tx_data_r;
    assign uart.tx_start = tx_start_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            phase           <= PH_SEND;
            cnt             <= '0;
            shot_addr       <= 8'h00;
            res_code        <= 2'b00;
            tx_data_r       <= 8'h00;
            tx_start_r      <= 1'b0;
            check_in        <= 8'h00;
            addres_recieved <= 1'b0;
            msg_in          <= 2'b00;
            my_turn         <= is_host;
            timeout         <= 1'b0;
        end else begin
            state           <= state_nxt;
            phase           <= phase_nxt;
            cnt             <= cnt_nxt;
            shot_addr       <= shot_addr_nxt;
            res_code        <= res_code_nxt;
            tx_data_r       <= tx_data_nxt;
            tx_start_r      <= tx_start_nxt;
            check_in        <= check_in_nxt;
            addres_recieved <= addr_rcv_nxt;
            msg_in          <= msg_in_nxt;
            my_turn         <= my_turn_nxt;
            timeout         <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        cnt_nxt       = cnt;
        shot_addr_nxt = shot_addr;
        res_code_nxt  = res_code;
        tx_data_nxt   = tx_data_r;
        tx_start_nxt  = 1'b0;
        check_in_nxt  = check_in;
        addr_rcv_nxt  = addres_recieved;
        msg_in_nxt    = msg_in;
        my_turn_nxt   = my_turn;
        timeout_nxt   = 1'b0;
        tx_byte       = 8'h00;
        tx_after      = IDLE;

        case (state)
            TX_SH_H:  begin tx_byte = HDR_SHOT;          tx_after = TX_SH_A;    end
            TX_SH_A:  begin tx_byte = shot_addr;         tx_after = WAIT_RES_H; end
            TX_RES_H: begin tx_byte = HDR_RES;           tx_after = TX_RES_D;   end
            TX_RES_D: begin tx_byte = {6'b0, res_code};  tx_after = IDLE;       end
            default:  ;
        endcase

        case (state)
            IDLE: begin
                if (uart.rx_valid && uart.rx_data == HDR_SHOT) begin
                    state_nxt = RX_SH_A;
                end else if (fire && my_turn && ships_ready) begin
                    shot_addr_nxt = mouse_pos;
                    state_nxt     = TX_SH_H;
                    // Header goes out straight from IDLE so a click reaches tx_start in one cycle.
                    if (!uart.tx_busy) begin
                        tx_data_nxt  = HDR_SHOT;
                        tx_start_nxt = 1'b1;
                        phase_nxt    = PH_GAP;
                    end else begin
                        phase_nxt    = PH_SEND;
                    end
                end
            end

            TX_SH_H, TX_SH_A, TX_RES_H, TX_RES_D: begin
                case (phase)
                    PH_SEND: begin
                        if (!uart.tx_busy) begin
                            tx_data_nxt  = tx_byte;
                            tx_start_nxt = 1'b1;
                            phase_nxt    = PH_GAP;
                        end
                    end
                    PH_GAP: phase_nxt = PH_DRAIN;
                    default: begin
                        if (!uart.tx_busy) begin
                            phase_nxt = PH_SEND;
                            state_nxt = tx_after;
                            cnt_nxt   = '0;
                        end
                    end
                endcase
            end

            WAIT_RES_H: begin
                if (cnt == CNT_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (uart.rx_valid && uart.rx_data == HDR_RES)
                        state_nxt = WAIT_RES_D;
                end
            end

            WAIT_RES_D: begin
                if (cnt == CNT_LAST) begin
                    timeout_nxt = 1'b1;
                    state_nxt   = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if (uart.rx_valid) begin
                        msg_in_nxt = uart.rx_data[1:0];
                        state_nxt  = APPLY_RES;
                    end
                end
            end

            // msg_in stays up through the first frame_tick and drops right after it.
            APPLY_RES: begin
                if (frame_tick) begin
                    msg_in_nxt = 2'b00;
                    if (msg_in == 2'b11)
                        my_turn_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end

            RX_SH_A: begin
                if (uart.rx_valid) begin
                    check_in_nxt = uart.rx_data;
                    addr_rcv_nxt = 1'b1;
                    state_nxt    = EVAL;
                end
            end

            EVAL: begin
                if (frame_tick) begin
                    addr_rcv_nxt = 1'b0;
                    state_nxt    = CAPTURE;
                end
            end

            CAPTURE: begin
                res_code_nxt = msg_out;
                if (msg_out == 2'b11)
                    my_turn_nxt = 1'b1;
                phase_nxt = PH_SEND;
                state_nxt = TX_RES_H;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_shot_exchange.sv
// Directed bench for shot_exchange: local miss/hit, remote shot, guards, timeout and mid-frame reset.
// A small UART model stays busy for four cycles after each tx_start and logs every transmitted byte.
module tb_shot_exchange;

    logic       clk;
    logic       rst_n;
    logic       is_host;
    logic       fire;
    logic [7:0] mouse_pos;
    logic       ships_ready;
    logic       frame_tick;
    logic [1:0] msg_out;
    logic [7:0] check_in;
    logic       addres_recieved;
    logic [1:0] msg_in;
    logic       my_turn;
    logic       timeout;

    shot_exchange_if uart_if ();

    shot_exchange #(
        .TIMEOUT_CYCLES(50),
        .HDR_SHOT      (8'hA5),
        .HDR_RES       (8'h5A)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .is_host        (is_host),
        .fire           (fire),
        .mouse_pos      (mouse_pos),
        .ships_ready    (ships_ready),
        .frame_tick     (frame_tick),
        .msg_out        (msg_out),
        .uart           (uart_if),
        .check_in       (check_in),
        .addres_recieved(addres_recieved),
        .msg_in         (msg_in),
        .my_turn        (my_turn),
        .timeout        (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         last_start_cyc = 0;
    int         to_count = 0;
    int         to_cyc = 0;
    int         tx_base = 0;
    logic [7:0] tx_q[$];
    logic [2:0] busy_cnt;

    // UART transmitter model: busy for four cycles after each request.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_cnt <= 3'd0;
        else if (uart_if.tx_start)
            busy_cnt <= 3'd4;
        else if (busy_cnt != 3'd0)
            busy_cnt <= busy_cnt - 3'd1;
    end
    assign uart_if.tx_busy = (busy_cnt != 3'd0);

    always begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (uart_if.tx_start) begin
            tx_q.push_back(uart_if.tx_data);
            last_start_cyc = cyc;
        end
        if (timeout) begin
            to_count = to_count + 1;
            to_cyc   = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        uart_if.rx_data  = b;
        uart_if.rx_valid = 1'b1;
        @(negedge clk);
        uart_if.rx_valid = 1'b0;
    endtask

    task automatic apply_reset(input logic host);
        rst_n            = 1'b0;
        is_host          = host;
        fire             = 1'b0;
        frame_tick       = 1'b0;
        msg_out          = 2'b00;
        uart_if.rx_valid = 1'b0;
        uart_if.rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tx_base = tx_q.size();
    endtask

    task automatic do_fire(input logic [7:0] addr);
        @(negedge clk);
        fire      = 1'b1;
        mouse_pos = addr;
        @(negedge clk);
        fire      = 1'b0;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 200 && tx_q.size() < tx_base + n; i++)
            @(negedge clk);
        checkOutput("tx_byte_count", 32'(tx_q.size()), 32'(tx_base + n));
    endtask

    task automatic pulse_tick_msg(input logic [1:0] verdict);
        @(negedge clk);
        frame_tick = 1'b1;
        msg_out    = verdict;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic local_shot(input logic [7:0] addr, input logic [7:0] reply, input logic exp_turn);
        do_fire(addr);
        checkOutput("fire_tx_start", 32'(uart_if.tx_start), 32'h1);
        checkOutput("fire_tx_hdr", 32'(uart_if.tx_data), 32'hA5);
        wait_tx(2);
        checkOutput("shot_hdr", 32'(tx_q[tx_base]), 32'hA5);
        checkOutput("shot_addr", 32'(tx_q[tx_base + 1]), 32'(addr));
        repeat (8) @(negedge clk);
        applyStimulus(8'h5A);
        applyStimulus(reply);
        checkOutput("msg_in_set", 32'(msg_in), 32'(reply[1:0]));
        repeat (3) @(negedge clk);
        checkOutput("msg_in_hold", 32'(msg_in), 32'(reply[1:0]));
        @(negedge clk);
        frame_tick = 1'b1;
        checkOutput("msg_in_at_tick", 32'(msg_in), 32'(reply[1:0]));
        @(negedge clk);
        frame_tick = 1'b0;
        checkOutput("msg_in_cleared", 32'(msg_in), 32'h0);
        checkOutput("turn_after_result", 32'(my_turn), 32'(exp_turn));
        tx_base = tx_q.size();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got hang, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base_to;
        int start_cyc;
        ships_ready = 1'b1;
        mouse_pos   = 8'h00;

        apply_reset(1'b1);
        checkOutput("rst_tx_data", 32'(uart_if.tx_data), 32'h0);
        checkOutput("rst_tx_start", 32'(uart_if.tx_start), 32'h0);
        checkOutput("rst_check_in", 32'(check_in), 32'h0);
        checkOutput("rst_addr_rcv", 32'(addres_recieved), 32'h0);
        checkOutput("rst_msg_in", 32'(msg_in), 32'h0);
        checkOutput("rst_my_turn_host", 32'(my_turn), 32'h1);
        checkOutput("rst_timeout", 32'(timeout), 32'h0);

        $display("[TB] local miss");
        local_shot(8'h34, 8'h03, 1'b0);

        $display("[TB] fire guard, not our turn");
        do_fire(8'h21);
        repeat (10) @(negedge clk);
        checkOutput("guard_turn", 32'(tx_q.size()), 32'(tx_base));

        $display("[TB] local hit");
        apply_reset(1'b1);
        local_shot(8'h34, 8'h02, 1'b1);

        $display("[TB] fire guard, ships not ready");
        ships_ready = 1'b0;
        do_fire(8'h55);
        repeat (10) @(negedge clk);
        checkOutput("guard_ships", 32'(tx_q.size()), 32'(tx_base));
        ships_ready = 1'b1;

        $display("[TB] stray byte in IDLE");
        applyStimulus(8'h11);
        applyStimulus(8'h57);
        checkOutput("stray_addr_rcv", 32'(addres_recieved), 32'h0);
        checkOutput("stray_check_in", 32'(check_in), 32'h0);

        $display("[TB] timeout");
        base_to = to_count;
        do_fire(8'h66);
        wait_tx(2);
        start_cyc = last_start_cyc;
        repeat (4) @(negedge clk);
        applyStimulus(8'hA5);
        applyStimulus(8'h57);
        checkOutput("wait_shot_ignored", 32'(addres_recieved), 32'h0);
        for (int i = 0; i < 200 && to_count == base_to; i++)
            @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("timeout_pulses", 32'(to_count - base_to), 32'h1);
        checkOutput("timeout_delay", 32'(to_cyc - start_cyc), 32'd56);
        checkOutput("timeout_turn", 32'(my_turn), 32'h1);
        tx_base = tx_q.size();
        do_fire(8'h77);
        checkOutput("refire_tx_start", 32'(uart_if.tx_start), 32'h1);

        $display("[TB] remote shot");
        apply_reset(1'b0);
        checkOutput("rst_my_turn_guest", 32'(my_turn), 32'h0);
        applyStimulus(8'hA5);
        applyStimulus(8'h57);
        checkOutput("remote_check_in", 32'(check_in), 32'h57);
        checkOutput("remote_addr_rcv", 32'(addres_recieved), 32'h1);
        repeat (2) @(negedge clk);
        checkOutput("remote_addr_hold", 32'(addres_recieved), 32'h1);
        pulse_tick_msg(2'b11);
        checkOutput("remote_addr_drop", 32'(addres_recieved), 32'h0);
        wait_tx(2);
        checkOutput("result_hdr", 32'(tx_q[tx_base]), 32'h5A);
        checkOutput("result_data", 32'(tx_q[tx_base + 1]), 32'h03);
        checkOutput("remote_turn", 32'(my_turn), 32'h1);
        repeat (8) @(negedge clk);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_tx_data", 32'(uart_if.tx_data), 32'h0);
        checkOutput("midrst_check_in", 32'(check_in), 32'h0);
        checkOutput("midrst_my_turn", 32'(my_turn), 32'h0);
        checkOutput("midrst_msg_in", 32'(msg_in), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h57);
        repeat (2) @(negedge clk);
        checkOutput("midrst_addr_rcv", 32'(addres_recieved), 32'h0);
        checkOutput("midrst_addr_drop", 32'(check_in), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shot_exchange.md
# shot_exchange

Turn and shot protocol controller between the UART byte link and `game_board`. Sends local shots (clicked cell address) to the opponent and receives opponent shots. Presents incoming addresses to `game_board` as `check_in`/`addres_recieved`, returns its `msg_out` verdict over UART, and delivers the opponent's verdict as `msg_in`. Holds every board-facing signal across the once-per-frame `game_board` update point and tracks whose turn it is.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 100_000_000: cycles to wait for an opponent RESULT before abandoning a shot.
- `HDR_SHOT`, default 8'hA5: header byte of a SHOT frame.
- `HDR_RES`, default 8'h5A: header byte of a RESULT frame.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `is_host` in 1: sampled during reset. 1 = this side fires first.
- `fire` in 1: single-cycle click pulse. Requests a shot at `mouse_pos`.
- `mouse_pos` in 8: target cell, {row[3:0], col[3:0]}.
- `ships_ready` in 1: high once the local `ship_count` ≥ 10.
- `frame_tick` in 1: pulse on the `game_board` update cycle (hcount==1, vcount==0).
- `msg_out` in 2: `game_board` verdict. 2'b10 = hit, 2'b11 = miss, 2'b00 = repeat or invalid.
- `rx_data` in 8: received UART byte.
- `rx_valid` in 1: single-cycle strobe that qualifies `rx_data`.
- `tx_busy` in 1: UART transmitter busy.
- `tx_data` out 8: byte to transmit.
- `tx_start` out 1: single-cycle transmit request.
- `check_in` out 8: opponent's shot address to `game_board`.
- `addres_recieved` out 1: `check_in` is valid and must be evaluated.
- `msg_in` out 2: opponent's verdict on our last shot, to `game_board`.
- `my_turn` out 1: local player may fire.
- `timeout` out 1: single-cycle pulse when a RESULT wait expires.

## Operation

- Frames are two bytes.
  - SHOT = `HDR_SHOT`, then the address.
  - RESULT = `HDR_RES`, then {6'b0, verdict}.
- FSM states: IDLE, TX_SH_H, TX_SH_A, WAIT_RES_H, WAIT_RES_D, APPLY_RES, RX_SH_A, EVAL, CAPTURE, TX_RES_H, TX_RES_D.
- IDLE, local shot:
  - Condition: `fire` && `my_turn` && `ships_ready`.
  - Latch `mouse_pos` and go to TX_SH_H.
  - `fire` is ignored in any other state, or when `my_turn`==0 or `ships_ready`==0.
- IDLE, remote shot: `rx_valid` with `rx_data`==`HDR_SHOT` goes to RX_SH_A. Any other byte is discarded.
- TX states:
  - Drive `tx_data` and pulse `tx_start` only in a cycle where `tx_busy`==0.
  - Then wait one cycle, then wait for `tx_busy`==0 before the next byte or state.
- Path after a local shot:
  - TX_SH_A goes to WAIT_RES_H; the timeout counter is cleared.
  - WAIT_RES_H: `HDR_RES` goes to WAIT_RES_D. Other bytes are discarded and the counter keeps running.
  - WAIT_RES_D: next `rx_valid` latches `rx_data[1:0]`, drives it on `msg_in`, and goes to APPLY_RES.
  - APPLY_RES:
    - Hold `msg_in` until the first `frame_tick`; on the cycle after it, clear `msg_in` to 2'b00.
    - Verdict 2'b11 (miss) clears `my_turn`. 2'b10 (hit) keeps it. 2'b00 leaves `my_turn` unchanged.
    - Return to IDLE.
- Path after a remote shot:
  - RX_SH_A: next `rx_valid` latches `check_in`, asserts `addres_recieved`, and goes to EVAL.
  - EVAL: wait for `frame_tick`, then go to CAPTURE.
  - CAPTURE, one cycle:
    - Sample `msg_out` (already updated by `game_board`) and deassert `addres_recieved`.
    - If `msg_out`==2'b11, set `my_turn`. Hit or 2'b00 leaves it 0.
    - Go to TX_RES_H; TX_RES_D then sends {6'b0, sampled verdict}.
- Timeout:
  - When the counter reaches `TIMEOUT_CYCLES`-1 in WAIT_RES_H or WAIT_RES_D, pulse `timeout` and return to IDLE.
  - `my_turn` stays 1, so the player may re-fire.
- `HDR_SHOT` received while in WAIT_RES_* is discarded; there is no turn collision.

## Timing

- Reset values:
  - `tx_data`, `check_in`: 8'h00.
  - `tx_start`, `addres_recieved`, `timeout`: 0.
  - `msg_in`: 2'b00.
  - `my_turn`: `is_host`.
  - FSM: IDLE; timeout counter: 0.
- All outputs are registered. `tx_start` and `timeout` are one cycle wide.
- `fire` to first `tx_start`: 1 cycle when `tx_busy`==0.
- `addres_recieved` rises 1 cycle after the address byte's `rx_valid`. It falls the cycle after the first subsequent `frame_tick`, i.e. it stays high across exactly one `frame_tick`.
- `msg_in` is likewise nonzero across exactly one `frame_tick`.
- `frame_tick` coincident with the entry into EVAL/APPLY_RES counts as that state's tick.
- Asserting `rst_n` low mid-frame immediately aborts the transfer:
  - All outputs return to reset values.
  - A partially received frame is dropped.

## Test plan

- Local miss:
  - `is_host`=1, `ships_ready`=1; `fire` with `mouse_pos`=8'h34 → `tx_data` 8'hA5, then 8'h34.
  - Inject rx 8'h5A, 8'h03 → `msg_in`=2'b11 held through one `frame_tick`, then 2'b00; `my_turn`=0.
- Local hit: same as above but inject 8'h5A, 8'h02 → `msg_in`=2'b10 for one `frame_tick`; `my_turn` stays 1.
- Remote shot:
  - `is_host`=0; inject 8'hA5, 8'h57 → `check_in`=8'h57, `addres_recieved`=1.
  - At `frame_tick`, set `msg_out`=2'b11 → next cycle `addres_recieved`=0; tx sends 8'h5A, then 8'h03; `my_turn`=1.
- Guards: `fire` with `my_turn`=0 or `ships_ready`=0 → no `tx_start`. Stray byte 8'h11 in IDLE → ignored.
- Timeout: `TIMEOUT_CYCLES`=50; fire, then no reply → `timeout` pulses 50 cycles after entering WAIT_RES_H; FSM in IDLE; `my_turn`=1.
- Reset mid-frame: pull `rst_n` low between 8'hA5 and the address byte → all outputs at reset values; the following address byte is ignored.
